jtopl_eg_seq: RTL and testbench
===============================

JTOPL_EG_SEQ -- requirements
Module: jtopl_eg_seq

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes occur on its rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-003 The block SHALL have port cen, input, 1 bit: clock enable; one slot step per cycle with cen=1.
REQ-004 The block SHALL have port keyon, input, 1 bit: key-on register bit of the slot currently addressed by slot.
REQ-005 The block SHALL have port slot, output, 5 bits: current slot index, 0..17.
REQ-006 The block SHALL have port zero, output, 1 bit: high while slot==0.
REQ-007 The block SHALL have port keyon_now, output, 1 bit: key-on rising edge for the current slot.
REQ-008 The block SHALL have port keyoff_now, output, 1 bit: key-on falling edge for the current slot.
REQ-009 The block SHALL have port state_in, output, 3 bits: stored envelope state of the current slot, one-hot (ATTACK=001, DECAY=010, RELEASE=100).
REQ-010 The block SHALL have port eg_in, output, 10 bits: stored attenuation of the current slot (0 = loudest, 0x3FF = silent).
REQ-011 The block SHALL have port cnt_in, output, 1 bit: stored rate-counter LSB of the current slot.
REQ-012 The block SHALL have port sum_up_in, output, 1 bit: stored sum-up flag of the current slot.
REQ-013 The block SHALL have port eg_cnt, output, 15 bits: global envelope counter.
REQ-014 The block SHALL have port state_next, input, 3 bits: next state from the envelope combinational stage.
REQ-015 The block SHALL have port pure_eg_out, input, 10 bits: next attenuation from the combinational stage.
REQ-016 The block SHALL have port cnt_lsb, input, 1 bit: rate-counter LSB from the combinational stage.
REQ-017 The block SHALL have port sum_up_out, input, 1 bit: sum-up flag from the combinational stage.

Function
REQ-018 The block SHALL keep per-slot storage as an 18-entry circular shift register holding {state 3b, eg 10b, keyon_last 1b, cnt 1b, sum_up 1b}; the head entry always belongs to slot.
REQ-019 The block SHALL drive state_in, eg_in, cnt_in and sum_up_in from head-entry fields, registered, with no combinational path from any input.
REQ-020 On a rising edge with cen=1, the block SHALL rotate the shift register one position and write {state_next, pure_eg_out, keyon, cnt_lsb, sum_up_out} into the entry leaving the head, so slot s is updated exactly once per 18 cen cycles.
REQ-021 The block SHALL compute keyon_now = keyon & ~keyon_last(head) and keyoff_now = ~keyon & keyon_last(head) combinationally, and they SHALL never be high together.
REQ-022 On each cen cycle the block SHALL increment slot by 1, wrapping 17 -> 0.
REQ-023 The block SHALL increment eg_cnt by 1 on the cen cycle where slot==17, wrapping 0x7FFF -> 0x0000, so eg_cnt advances once per 18 slots.
REQ-024 With cen=0, all registers SHALL hold; keyon_now and keyoff_now SHALL still reflect the current keyon against the held head entry.
REQ-025 The block SHALL store state_next values that are not one-hot unchanged; it SHALL perform no encoding checks.
REQ-026 The block SHALL accept a keyon change in any slot; an edge presented while cen=0 SHALL be recorded only on the next cen cycle of that slot.

Reset
REQ-027 When rst_n=0 at a rising edge, regardless of cen, the block SHALL load every entry as state=RELEASE (100), eg=0x3FF, keyon_last=0, cnt=0, sum_up=0, and set slot=0 and eg_cnt=0.
REQ-028 After reset, zero SHALL be 1, state_in SHALL be 100, eg_in SHALL be 0x3FF, and cnt_in, sum_up_in and eg_cnt SHALL be 0.
REQ-029 Reset asserted mid-round SHALL discard the pending write-back, and the first post-reset cen cycle SHALL address slot 0.

Verification
REQ-030 The bench SHALL apply reset then hold cen=1 for 18 cycles with comb inputs tied to {001, 0x155, 1, 1}; it SHALL check that slot steps 0..17 and back to 0, that eg_cnt goes 0 -> 1 after the slot-17 cycle, and that revisited slot 0 shows state_in=001, eg_in=0x155, cnt_in=1, sum_up_in=1.
REQ-031 The bench SHALL set keyon=1 only while slot==5; it SHALL check keyon_now=1 at slot 5 on the first visit and 0 on the next visit, then with keyon=0 at slot 5 check keyoff_now=1 once.
REQ-032 The bench SHALL preload eg_cnt to 0x7FFF via 32767*18 cen cycles (or force) and check a wrap to 0x0000 after the next slot-17 cycle.
REQ-033 The bench SHALL toggle cen with a 1-in-3 duty and check that slot and eg_cnt advance only on cen cycles, that outputs are stable otherwise, and that the slot 3 write-back equals the inputs present on its cen cycle.
REQ-034 The bench SHALL assert rst_n=0 for one cycle at slot 9 with modified entries and check all 18 slots read back 100/0x3FF/0/0 on the next full round, with slot=0 first.

Source files
------------

// File: rtl/jtopl_eg_seq.sv
`default_nettype none
// ============================================================================
//  Module   : jtopl_eg_seq
//  Purpose  : Envelope-generator slot sequencer. Per-slot envelope state
//             lives in an 18-entry circular shift register. The head entry
//             always belongs to the slot currently addressed by 'slot'.
//             Each cen cycle does three things:
//               - rotates the ring by one entry,
//               - writes the combinational stage's results into the entry
//                 leaving the head,
//               - advances the slot counter.
//             The global envelope counter advances once per full round.
//  Ports    :
//    clk          system clock, rising edge
//    rst_n        synchronous active-low reset
//    cen          clock enable, one slot step per enabled cycle
//    keyon        key-on bit of the current slot
//    slot         current slot index 0..17
//    zero         high while slot == 0
//    keyon_now    key-on rising edge for the current slot
//    keyoff_now   key-on falling edge for the current slot
//    state_in     stored one-hot envelope state of the current slot
//    eg_in        stored attenuation of the current slot
//    cnt_in       stored rate-counter LSB of the current slot
//    sum_up_in    stored sum-up flag of the current slot
//    eg_cnt       global envelope counter
//    state_next   next state from the combinational stage
//    pure_eg_out  next attenuation from the combinational stage
//    cnt_lsb      rate-counter LSB from the combinational stage
//    sum_up_out   sum-up flag from the combinational stage
//  Revision : 1.0 - initial release
// ============================================================================
module jtopl_eg_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        keyon,
  output logic [4:0]  slot,
  output logic        zero,
  output logic        keyon_now,
  output logic        keyoff_now,
  output logic [2:0]  state_in,
  output logic [9:0]  eg_in,
  output logic        cnt_in,
  output logic        sum_up_in,
  output logic [14:0] eg_cnt,
  input  logic [2:0]  state_next,
  input  logic [9:0]  pure_eg_out,
  input  logic        cnt_lsb,
  input  logic        sum_up_out
);

  localparam int         SLOTS      = 18;
  localparam logic [4:0] LAST_SLOT  = 5'd17;
  localparam logic [2:0] ST_RELEASE = 3'b100;

  typedef struct packed {
    logic [2:0] state;
    logic [9:0] eg;
    logic       keyon_last;
    logic       cnt;
    logic       sum_up;
  } entry_t;

  localparam entry_t ENTRY_RESET = '{
    state:      ST_RELEASE,
    eg:         10'h3FF,
    keyon_last: 1'b0,
    cnt:        1'b0,
    sum_up:     1'b0
  };

  // ring[0] is the head: it always holds the data of the slot in 'slot'.
  entry_t ring [SLOTS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOTS; i++) begin
        ring[i] <= ENTRY_RESET;
      end
      slot   <= 5'd0;
      eg_cnt <= 15'd0;
    end else if (cen) begin
      // Rotate toward the head. The departing head entry re-enters at the
      // tail carrying the freshly computed values, so it returns to the
      // head exactly one round later.
      for (int i = 0; i < SLOTS - 1; i++) begin
        ring[i] <= ring[i+1];
      end
      ring[SLOTS-1] <= '{
        state:      state_next,
        eg:         pure_eg_out,
        keyon_last: keyon,
        cnt:        cnt_lsb,
        sum_up:     sum_up_out
      };
      if (slot == LAST_SLOT) begin
        slot   <= 5'd0;
        eg_cnt <= eg_cnt + 15'd1;
      end else begin
        slot   <= slot + 5'd1;
      end
    end
  end

  // Stored fields come straight from the head register.
  assign state_in  = ring[0].state;
  assign eg_in     = ring[0].eg;
  assign cnt_in    = ring[0].cnt;
  assign sum_up_in = ring[0].sum_up;
  assign zero      = (slot == 5'd0);

  // Edge detection against the key-on bit stored on this slot's last
  // visit. The two terms are mutually exclusive by construction.
  assign keyon_now  =  keyon & ~ring[0].keyon_last;
  assign keyoff_now = ~keyon &  ring[0].keyon_last;

endmodule
`default_nettype wire

// File: tb/tb_jtopl_eg_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jtopl_eg_seq
//  Purpose  : Self-checking bench for jtopl_eg_seq.
//             The stimulus side drives inputs just after each rising edge.
//             Before each edge it queues the responses expected from the
//             current state, tagged with a cycle stamp. Those expectations
//             come from hand-computed constants and from a per-slot
//             reference table. A monitor process samples on the falling
//             edge, pops every expectation due, and compares it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jtopl_eg_seq;

  logic        clk = 1'b0;
  logic        rst_n, cen, keyon, cnt_lsb, sum_up_out;
  logic [2:0]  state_next;
  logic [9:0]  pure_eg_out;
  logic [4:0]  slot;
  logic        zero, keyon_now, keyoff_now, cnt_in, sum_up_in;
  logic [2:0]  state_in;
  logic [9:0]  eg_in;
  logic [14:0] eg_cnt;

  jtopl_eg_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cen         (cen),
    .keyon       (keyon),
    .slot        (slot),
    .zero        (zero),
    .keyon_now   (keyon_now),
    .keyoff_now  (keyoff_now),
    .state_in    (state_in),
    .eg_in       (eg_in),
    .cnt_in      (cnt_in),
    .sum_up_in   (sum_up_in),
    .eg_cnt      (eg_cnt),
    .state_next  (state_next),
    .pure_eg_out (pure_eg_out),
    .cnt_lsb     (cnt_lsb),
    .sum_up_out  (sum_up_out)
  );

  always #5 clk = ~clk;

  // Field selectors
  localparam logic [3:0] F_SLOT = 4'd0, F_ZERO = 4'd1, F_KON = 4'd2,
                         F_KOFF = 4'd3, F_ST = 4'd4, F_EG = 4'd5,
                         F_CNT = 4'd6, F_SUM = 4'd7, F_EGC = 4'd8;

  typedef struct packed {
    int          cyc;
    logic [3:0]  sel;
    logic [14:0] val;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [14:0] actual(input logic [3:0] sel);
    case (sel)
      F_SLOT:  return {10'd0, slot};
      F_ZERO:  return {14'd0, zero};
      F_KON:   return {14'd0, keyon_now};
      F_KOFF:  return {14'd0, keyoff_now};
      F_ST:    return {12'd0, state_in};
      F_EG:    return {5'd0, eg_in};
      F_CNT:   return {14'd0, cnt_in};
      F_SUM:   return {14'd0, sum_up_in};
      F_EGC:   return eg_cnt;
      default: return 15'd0;
    endcase
  endfunction

  function automatic string fname(input logic [3:0] sel);
    case (sel)
      F_SLOT:  return "slot";
      F_ZERO:  return "zero";
      F_KON:   return "keyon_now";
      F_KOFF:  return "keyoff_now";
      F_ST:    return "state_in";
      F_EG:    return "eg_in";
      F_CNT:   return "cnt_in";
      F_SUM:   return "sum_up_in";
      F_EGC:   return "eg_cnt";
      default: return "unknown";
    endcase
  endfunction

  // Monitor: compares everything due at this falling edge.
  initial begin
    exp_t        e;
    logic [14:0] a;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        a = actual(e.sel);
        total++;
        if (a !== e.val) begin
          bad++;
          $display("FAIL %s cyc=%0d actual=%h required=%h",
                   fname(e.sel), e.cyc, a, e.val);
        end
      end
    end
  end

  // Per-slot reference table
  logic [2:0]  m_st  [18];
  logic [9:0]  m_eg  [18];
  logic        m_kl  [18];
  logic        m_cnt [18];
  logic        m_su  [18];
  int          s;
  logic [14:0] egc;

  task automatic want(input logic [3:0] sel, input logic [14:0] v);
    exp_t e;
    e.cyc = cyc;
    e.sel = sel;
    e.val = v;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 18; i++) begin
      m_st[i]  = 3'b100;
      m_eg[i]  = 10'h3FF;
      m_kl[i]  = 1'b0;
      m_cnt[i] = 1'b0;
      m_su[i]  = 1'b0;
    end
    s   = 0;
    egc = 15'd0;
  endtask

  // One clock: drive inputs, queue expectations for the current state, step.
  task automatic run(input logic c, input logic k, input logic [2:0] st,
                     input logic [9:0] e, input logic cl, input logic su);
    cen = c; keyon = k; state_next = st; pure_eg_out = e;
    cnt_lsb = cl; sum_up_out = su;
    want(F_SLOT, 15'(s));
    want(F_ZERO, 15'(s == 0));
    want(F_KON,  15'(k & ~m_kl[s]));
    want(F_KOFF, 15'(~k & m_kl[s]));
    want(F_ST,   15'(m_st[s]));
    want(F_EG,   15'(m_eg[s]));
    want(F_CNT,  15'(m_cnt[s]));
    want(F_SUM,  15'(m_su[s]));
    want(F_EGC,  egc);
    step();
    if (c) begin
      m_st[s] = st; m_eg[s] = e; m_kl[s] = k; m_cnt[s] = cl; m_su[s] = su;
      if (s == 17) begin
        s   = 0;
        egc = egc + 15'd1;
      end else begin
        s = s + 1;
      end
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0; cen = 1'b1; keyon = 1'b1;
    state_next = 3'b011; pure_eg_out = 10'h0AA; cnt_lsb = 1'b1; sum_up_out = 1'b1;
    step();
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    logic       have3;
    logic [2:0] st3;
    logic [9:0] e3;
    logic       c3, su3, wrap;
    logic       cc;
    logic [2:0] stv;
    logic [9:0] egv;

    rst_n = 1'b0; cen = 1'b0; keyon = 1'b0;
    state_next = 3'b000; pure_eg_out = 10'h000; cnt_lsb = 1'b0; sum_up_out = 1'b0;
    step();
    step();
    model_reset();
    rst_n = 1'b1;

    // Reset state, hand values
    want(F_SLOT, 15'd0); want(F_ZERO, 15'd1); want(F_ST, 15'h4);
    want(F_EG, 15'h3FF); want(F_CNT, 15'd0); want(F_SUM, 15'd0); want(F_EGC, 15'd0);

    // One full round with constant combinational inputs
    for (int i = 0; i < 18; i++) begin
      want(F_SLOT, 15'(i));
      want(F_EGC, 15'd0);
      run(1'b1, 1'b0, 3'b001, 10'h155, 1'b1, 1'b1);
    end
    want(F_SLOT, 15'd0); want(F_ZERO, 15'd1); want(F_EGC, 15'd1);
    want(F_ST, 15'h1); want(F_EG, 15'h155); want(F_CNT, 15'd1); want(F_SUM, 15'd1);

    // Key-on edges on slot 5 only
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 18; i++) begin
        if (s == 5) begin
          want(F_KON,  15'(r == 0));
          want(F_KOFF, 15'(r == 2));
        end
        run(1'b1, (s == 5) && (r < 2), 3'b001, 10'h155, 1'b1, 1'b1);
      end
    end

    // cen 1-in-3, inputs changing every cycle (including non-one-hot states)
    have3 = 1'b0; st3 = '0; e3 = '0; c3 = 1'b0; su3 = 1'b0;
    for (int k = 0; k < 108; k++) begin
      cc  = (k % 3 == 0);
      stv = 3'(k % 8);
      egv = 10'(k * 37 + 11);
      if (s == 3 && have3) begin
        want(F_ST, 15'(st3)); want(F_EG, 15'(e3));
        want(F_CNT, 15'(c3)); want(F_SUM, 15'(su3));
      end
      if (cc && s == 3) begin
        have3 = 1'b1; st3 = stv; e3 = egv;
        c3 = 1'((k >> 1) & 1); su3 = 1'((k >> 2) & 1);
      end
      run(cc, (k % 5) < 2, stv, egv, 1'((k >> 1) & 1), 1'((k >> 2) & 1));
    end

    // eg_cnt wrap from 0x7FFF
    force dut.eg_cnt = 15'h7FFF;
    #1;
    release dut.eg_cnt;
    egc = 15'h7FFF;
    for (int i = 0; i < 18; i++) begin
      wrap = (s == 17);
      run(1'b1, 1'b0, 3'b010, 10'(i * 3), 1'b0, 1'b1);
      if (wrap) want(F_EGC, 15'd0);
    end

    // Modify entries up to slot 9, then reset mid-round
    for (int i = 0; i < 18; i++) begin
      if (s == 9) break;
      run(1'b1, 1'b1, 3'(s), 10'(s * 29 + 1), 1'b1, 1'b0);
    end
    pulse_reset();
    for (int i = 0; i < 18; i++) begin
      want(F_SLOT, 15'(i));
      want(F_ST, 15'h4); want(F_EG, 15'h3FF); want(F_CNT, 15'd0); want(F_SUM, 15'd0);
      run(1'b1, 1'b0, 3'b001, 10'h012, 1'b1, 1'b1);
    end

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL queue_drain actual=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
